// File: rtl/spi_reg_peripheral.sv
// SPI mode-0 target holding the five PWM configuration bytes, written by 16-bit frames.
// Optional feature macro: SPI_READBACK_EN (read frames shift reg[address] out on cipo).
module spi_reg_peripheral #(
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ncs,
  input  logic       sclk,
  input  logic       copi,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);
  localparam logic [4:0] CNT_FRAME  = 5'd16;
  localparam logic [4:0] CNT_MAX    = 5'd17;

  logic [SYNC_STAGES-1:0] ncs_sync_q, sclk_sync_q, copi_sync_q;
  logic                   ncs_dly_q, sclk_dly_q;
  logic                   ncs_s, sclk_s, copi_s;
  logic                   ncs_fall_s, ncs_rise_s, sclk_rise_s;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];
  logic        commit_s;

  // Synchronizers; ncs resets low so a select already asserted at reset release never forms a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_sync_q  <= '0;
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_dly_q   <= 1'b0;
      sclk_dly_q  <= 1'b0;
    end else begin
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_dly_q   <= ncs_sync_q[SYNC_STAGES-1];
      sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign ncs_s       = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s      = copi_sync_q[SYNC_STAGES-1];
  assign ncs_fall_s  = ~ncs_s & ncs_dly_q;
  assign ncs_rise_s  = ncs_s & ~ncs_dly_q;
  assign sclk_rise_s = sclk_s & ~sclk_dly_q;

  // Frame FSM; an sclk edge in the same cycle as the ncs rise is deliberately not shifted in.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    commit_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall_s) begin
          state_d = ST_RECV;
          cnt_d   = 5'd0;
          shift_d = 16'h0000;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (ncs_rise_s) begin
          state_d = ST_DONE;
        end else if (sclk_rise_s) begin
          shift_d = {shift_q[14:0], copi_s};
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 5'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        commit_s = (cnt_q == CNT_FRAME) && shift_q[15] && (shift_q[14:8] < NUM_REGS_A);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    for (int i = 0; i < NUM_REGS; i++) begin
      if (commit_s && (shift_q[14:8] == 7'(i))) begin
        regs_d[i] = shift_q[7:0];
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Frame state and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      shift_q <= 16'h0000;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

`ifdef SPI_READBACK_EN
  logic       sclk_fall_s;
  logic [7:0] rd_sel_s;
  logic [7:0] rd_q, rd_d;
  logic       cipo_q, cipo_d;

  assign sclk_fall_s = ~sclk_s & sclk_dly_q;

  // After the address byte, each sclk fall presents the next read bit; non-read frames shift zeros.
  always_comb begin
    rd_sel_s = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!shift_q[7] && (shift_q[6:0] == 7'(i))) begin
        rd_sel_s = regs_q[i];
      end else begin
        rd_sel_s = rd_sel_s;
      end
    end
    rd_d   = rd_q;
    cipo_d = cipo_q;
    if (state_q != ST_RECV) begin
      rd_d   = 8'h00;
      cipo_d = 1'b0;
    end else if (sclk_fall_s && (cnt_q == 5'd8)) begin
      cipo_d = rd_sel_s[7];
      rd_d   = {rd_sel_s[6:0], 1'b0};
    end else if (sclk_fall_s && (cnt_q > 5'd8) && (cnt_q < CNT_FRAME)) begin
      cipo_d = rd_q[7];
      rd_d   = {rd_q[6:0], 1'b0};
    end else begin
      rd_d   = rd_q;
    end
  end

  // Readback shifter and cipo output flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= 8'h00;
      cipo_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      cipo_q <= cipo_d;
    end
  end

  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

endmodule
